slot_alloc12: RTL and testbench
===============================

# slot_alloc12

Twelve-entry slot allocator that tracks a free bitmap and grants the highest-numbered free slot on request. It sits directly downstream of the 12-bit find-last-one encoder stage: the bitmap is fed into that encoder, and the encoded index is registered as the next grant candidate. It is used for tag, buffer and register-rename slot management, where a client requests a slot, holds it, and later returns it.

## Interface
- No parameters. Width is fixed at 12 slots with a 4-bit index.
- rst  in  1  asynchronous, active-high reset
- clk  in  1  clock
- alloc_req  in  1  allocation request; level, sampled every cycle
- alloc_ack  out  1  one-cycle pulse; a slot was granted
- alloc_slot  out  4  granted slot index; valid while alloc_ack=1, holds last value otherwise
- rdy  out  1  candidate is valid; a request this cycle will be granted
- free_req  in  1  return-slot strobe
- free_slot  in  4  slot index being returned
- free_err  out  1  one-cycle pulse: illegal free (index>11 or slot already free)
- free_cnt  out  4  number of free slots, 0..12
- none_free  out  1  free_cnt==0

## Operation
- Internal state: free_map[11:0] (1=free), cand_slot[3:0], and FSM {SCAN, READY, EMPTY}.
- SCAN: cand_slot <= encode(free_map); next state READY if |free_map, else EMPTY. rdy=0.
- READY: rdy=1. On alloc_req: clear free_map[cand_slot]; alloc_ack<=1; alloc_slot<=cand_slot; free_cnt decrements; next state SCAN. Without alloc_req, stay in READY.
- EMPTY: rdy=0. A legal free sets its bit and moves to SCAN. alloc_req is ignored; no ack and no queueing.
- Requests are never queued. A request seen while rdy=0 is dropped, and the client holds alloc_req until alloc_ack.
- Free (any state): a legal free sets free_map[free_slot] and increments free_cnt. The candidate is not recomputed on a free in READY; policy is "highest free at the last scan".
- Illegal free: free_slot>11 or bit already set. free_err<=1, no bitmap or count change.
- Simultaneous alloc and free in READY: both are applied; free_cnt is unchanged net. If free_slot==cand_slot, that is a double free: free_err pulses and the alloc still proceeds, so the bit ends cleared.
- free_cnt is a saturating-free 4-bit count that can never exceed 12 or go below 0 by construction. none_free is decoded from it combinationally.

## Timing
- Reset values: free_map=12'hFFF, state=SCAN, cand_slot=0, alloc_ack=0, alloc_slot=0, free_err=0, free_cnt=12, none_free=0, rdy=0.
- First rdy=1 occurs in the 2nd cycle after reset deassertion, i.e. after one SCAN cycle.
- A grant in cycle n gives alloc_ack/alloc_slot registered in n+1. rdy=0 in n+1 (SCAN) and rdy=1 again in n+2.
- Sustained throughput is one grant per 2 cycles.
- free_err is registered and appears 1 cycle after free_req.
- free_cnt and free_map update on the clock edge ending the request cycle.
- Asynchronous reset mid-operation returns every output to its reset value immediately. Outstanding slots are forgotten.

## Configuration
- SLOT_ALLOC_CHECK_EN defined: the illegal-free detection above is active and free_err pulses.
- SLOT_ALLOC_CHECK_EN undefined: free_err is tied to 0 and no legality logic is built.
  - Frees with free_slot>11 are ignored.
  - A double free of an in-range slot sets an already-set bit and must not increment free_cnt, so the count is gated by the old bit value.

## Structure
- Shared package slot_alloc_pkg holds:
  - NSLOT=12 and the slot index typedef (4-bit).
  - FSM state enum {SCAN, READY, EMPTY}.
  - Reset constant FREE_ALL=12'hFFF.
- One sub-module, slot_pick12: a combinational 12-bit highest-set-bit encoder producing a 4-bit index, or 15 when the input is zero. It is instantiated once on free_map.

## Test plan
- Reset, then hold alloc_req=1 -> acks with slots 11,10,…,0 on alternate cycles. After the 12th grant: none_free=1, state EMPTY, and no further acks.
- From full-allocated, free slot 5 -> free_cnt=1, rdy rises 2 cycles later, and the next request grants slot 5.
- In READY with cand=11, issue alloc_req and free of slot 3 in the same cycle -> ack slot 11, free_cnt unchanged, bit 3 set.
- With SLOT_ALLOC_CHECK_EN: free slot 14, then free an already-free slot 7 -> free_err pulses each time, free_cnt and map unchanged. Without the macro, the same stimulus -> free_err=0, count unchanged.
- Double free of the current candidate together with alloc -> free_err=1, ack granted, candidate bit cleared.
- Assert rst mid-sequence with 4 slots allocated -> outputs at reset values immediately, free_cnt=12, and the first post-reset grant is slot 11.

Source files
------------

// File: rtl/slot_alloc12_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slot_alloc_pkg
//  Description : Shared types and constants for the 12-entry slot allocator.
//                Slot count, slot index type, allocator FSM state encoding
//                and the all-free reset bitmap.
//  Revision    : 1.0  initial release
// ============================================================================
package slot_alloc_pkg;

    localparam int NSLOT = 12;
    localparam int IDXW  = 4;

    typedef logic [IDXW-1:0] slot_idx_t;

    // Allocator FSM states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        READY = 2'd1,
        EMPTY = 2'd2
    } state_t;

    // Every slot free.
    localparam logic [NSLOT-1:0] FREE_ALL = 12'hFFF;

    // Encoder result when no bit is set.
    localparam slot_idx_t NO_SLOT = 4'd15;

endpackage
`default_nettype wire

// File: rtl/slot_pick12.sv
`default_nettype none
// ============================================================================
//  Module      : slot_pick12
//  Description : Combinational 12-bit find-last-one encoder. Returns the index
//                of the highest set bit of i_map, or 15 when i_map is zero.
//  Ports       : i_map [11:0]  bitmap to encode
//                o_idx [3:0]   index of highest set bit (15 if none)
//  Revision    : 1.0  initial release
// ============================================================================
module slot_pick12
    import slot_alloc_pkg::*;
(
    input  logic [NSLOT-1:0] i_map,
    output logic [IDXW-1:0]  o_idx
);

    // Ascending scan: the last set bit visited is the highest one.
    always_comb begin
        o_idx = NO_SLOT;
        for (int i = 0; i < NSLOT; i++) begin
            if (i_map[i]) begin
                o_idx = slot_idx_t'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/slot_alloc12.sv
`default_nettype none
// ============================================================================
//  Module      : slot_alloc12
//  Description : Twelve-entry slot allocator. Tracks a free bitmap, registers
//                the highest free slot as the grant candidate during a SCAN
//                cycle, and grants it on request. Slots are returned through
//                the free port. Requests are never queued.
//  Ports       : rst         async active-high reset
//                clk         clock
//                alloc_req   allocation request (level)
//                alloc_ack   one-cycle grant pulse
//                alloc_slot  granted index, held between grants
//                rdy         candidate valid, a request now is granted
//                free_req    return-slot strobe
//                free_slot   index being returned
//                free_err    one-cycle illegal-free pulse
//                free_cnt    number of free slots (0..12)
//                none_free   free_cnt == 0
//  Config      : SLOT_ALLOC_CHECK_EN - when defined, illegal frees (index > 11
//                or slot already free) pulse free_err; otherwise free_err is 0.
//                Illegal frees never alter the bitmap or count in either build.
//  Revision    : 1.0  initial release
// ============================================================================
module slot_alloc12
    import slot_alloc_pkg::*;
(
    input  logic       rst,
    input  logic       clk,
    input  logic       alloc_req,
    output logic       alloc_ack,
    output logic [3:0] alloc_slot,
    output logic       rdy,
    input  logic       free_req,
    input  logic [3:0] free_slot,
    output logic       free_err,
    output logic [3:0] free_cnt,
    output logic       none_free
);

    localparam logic [NSLOT-1:0] c_ONE_HOT0 = 12'd1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NSLOT-1:0] r_free_map;
    logic [NSLOT-1:0] w_map_nxt;
    slot_idx_t        r_cand_slot;
    slot_idx_t        w_pick;
    logic             r_alloc_ack;
    slot_idx_t        r_alloc_slot;
    logic [3:0]       r_free_cnt;
    logic             w_rdy;

    logic [NSLOT-1:0] w_free_onehot;
    logic [NSLOT-1:0] w_cand_onehot;
    logic             w_free_ok;
    logic             w_free_legal;
    logic             w_grant;

    slot_pick12 u_pick (
        .i_map (r_free_map),
        .o_idx (w_pick)
    );

    // An out-of-range index shifts the bit out entirely, so the one-hot is
    // zero; the same decode gives both the range check and the old bit value.
    assign w_free_onehot = c_ONE_HOT0 << free_slot;
    assign w_cand_onehot = c_ONE_HOT0 << r_cand_slot;
    assign w_free_ok     = (|w_free_onehot) && !(|(r_free_map & w_free_onehot));
    assign w_free_legal  = free_req && w_free_ok;
    assign w_grant       = (r_state == READY) && alloc_req;

    // A legal free can never target the candidate (its bit is already set),
    // so set-then-clear ordering only matters for the double-free case, where
    // the alloc must win and leave the bit cleared.
    always_comb begin
        w_map_nxt = r_free_map;
        if (w_free_legal) begin
            w_map_nxt = w_map_nxt | w_free_onehot;
        end
        if (w_grant) begin
            w_map_nxt = w_map_nxt & ~w_cand_onehot;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    // EMPTY also leaves when the map is already non-zero, which covers a free
    // that landed during the SCAN cycle that decided the map was empty.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SCAN:    w_state_nxt = (|r_free_map) ? READY : EMPTY;
            READY:   if (alloc_req) w_state_nxt = SCAN;
            EMPTY:   if (w_free_legal || (|r_free_map)) w_state_nxt = SCAN;
            default: w_state_nxt = SCAN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_rdy = 1'b0;
        if (r_state == READY) begin
            w_rdy = 1'b1;
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_free_map   <= FREE_ALL;
            r_cand_slot  <= '0;
            r_alloc_ack  <= 1'b0;
            r_alloc_slot <= '0;
            r_free_cnt   <= 4'(NSLOT);
        end else begin
            r_free_map  <= w_map_nxt;
            r_alloc_ack <= w_grant;
            if (r_state == SCAN) begin
                r_cand_slot <= w_pick;
            end
            if (w_grant) begin
                r_alloc_slot <= r_cand_slot;
            end
            r_free_cnt <= r_free_cnt + {3'b000, w_free_legal} - {3'b000, w_grant};
        end
    end

`ifdef SLOT_ALLOC_CHECK_EN
    logic r_free_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_free_err <= 1'b0;
        end else begin
            r_free_err <= free_req && !w_free_ok;
        end
    end

    assign free_err = r_free_err;
`else
    assign free_err = 1'b0;
`endif

    assign alloc_ack  = r_alloc_ack;
    assign alloc_slot = r_alloc_slot;
    assign rdy        = w_rdy;
    assign free_cnt   = r_free_cnt;
    assign none_free  = (r_free_cnt == 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_slot_alloc12.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slot_alloc12
//  Description : Scoreboard bench for slot_alloc12. Stimulus pushes expected
//                grant slots and expected free_err pulses into queues; a
//                monitor on the falling edge pops and compares whenever the
//                DUT presents alloc_ack or free_err.
//  Config      : SLOT_ALLOC_CHECK_EN selects whether free_err pulses are
//                expected for illegal frees.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_slot_alloc12;

    logic       rst;
    logic       clk;
    logic       alloc_req;
    logic       alloc_ack;
    logic [3:0] alloc_slot;
    logic       rdy;
    logic       free_req;
    logic [3:0] free_slot;
    logic       free_err;
    logic [3:0] free_cnt;
    logic       none_free;

    int exp_slot_q[$];
    int exp_err_q[$];
    int vectors;
    int miscompares;

    slot_alloc12 dut (
        .rst        (rst),
        .clk        (clk),
        .alloc_req  (alloc_req),
        .alloc_ack  (alloc_ack),
        .alloc_slot (alloc_slot),
        .rdy        (rdy),
        .free_req   (free_req),
        .free_slot  (free_slot),
        .free_err   (free_err),
        .free_cnt   (free_cnt),
        .none_free  (none_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_err();
`ifdef SLOT_ALLOC_CHECK_EN
        exp_err_q.push_back(1);
`endif
    endtask

    // Bounded wait for the scoreboard to empty.
    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_slot_q.size() != 0 || exp_err_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_ack_pending"}, exp_slot_q.size(), 0);
        chk({name, "_err_pending"}, exp_err_q.size(), 0);
        exp_slot_q.delete();
        exp_err_q.delete();
    endtask

    // Monitor: compare every presented grant/error against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (alloc_ack) begin
                if (exp_slot_q.size() == 0) begin
                    chk("unexpected_ack_slot", int'(alloc_slot), -1);
                end else begin
                    chk("ack_slot", int'(alloc_slot), exp_slot_q.pop_front());
                end
            end
            if (free_err) begin
                if (exp_err_q.size() == 0) begin
                    chk("unexpected_free_err", 1, 0);
                end else begin
                    chk("free_err", 1, exp_err_q.pop_front());
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        alloc_req   = 1'b0;
        free_req    = 1'b0;
        free_slot   = 4'd0;

        // ---- reset values ----
        tick();
        tick();
        chk("rst_ack", int'(alloc_ack), 0);
        chk("rst_slot", int'(alloc_slot), 0);
        chk("rst_err", int'(free_err), 0);
        chk("rst_cnt", int'(free_cnt), 12);
        chk("rst_none", int'(none_free), 0);
        chk("rst_rdy", int'(rdy), 0);
        rst = 1'b0;
        #3;
        chk("scan_rdy", int'(rdy), 0);
        tick();
        chk("first_rdy", int'(rdy), 1);

        // ---- allocate all twelve: 11..0, one grant per two cycles ----
        for (int s = 11; s >= 0; s--) exp_slot_q.push_back(s);
        alloc_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            tick();
            chk("sweep_rate", exp_slot_q.size(), 11 - i);
        end
        tick();
        tick();
        tick();
        tick();
        chk("sweep_cnt", int'(free_cnt), 0);
        chk("sweep_none", int'(none_free), 1);
        chk("sweep_rdy", int'(rdy), 0);
        alloc_req = 1'b0;
        drain("sweep", 4);

        // ---- free slot 5 from fully allocated ----
        free_req  = 1'b1;
        free_slot = 4'd5;
        tick();
        free_req = 1'b0;
        chk("free5_cnt", int'(free_cnt), 1);
        chk("free5_none", int'(none_free), 0);
        chk("free5_rdy_early", int'(rdy), 0);
        tick();
        chk("free5_rdy", int'(rdy), 1);
        exp_slot_q.push_back(5);
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
        tick();
        drain("free5", 4);
        chk("free5_cnt_after", int'(free_cnt), 0);

        // ---- alloc + free of a different slot in the same cycle ----
        tick();
        free_req  = 1'b1;
        free_slot = 4'd11;
        tick();
        free_slot = 4'd10;
        tick();
        free_req = 1'b0;
        chk("mix_rdy", int'(rdy), 1);
        chk("mix_cnt_pre", int'(free_cnt), 2);
        exp_slot_q.push_back(11);
        alloc_req = 1'b1;
        free_req  = 1'b1;
        free_slot = 4'd3;
        tick();
        alloc_req = 1'b0;
        free_req  = 1'b0;
        chk("mix_cnt_net", int'(free_cnt), 2);
        tick();
        // Remaining free slots must be exactly 10 and 3.
        exp_slot_q.push_back(10);
        exp_slot_q.push_back(3);
        alloc_req = 1'b1;
        tick();
        tick();
        tick();
        tick();
        alloc_req = 1'b0;
        tick();
        drain("mix", 6);
        chk("mix_none", int'(none_free), 1);

        // ---- illegal frees: out of range, then already free ----
        free_req  = 1'b1;
        free_slot = 4'd7;
        tick();
        free_req = 1'b0;
        tick();
        chk("ill_setup_cnt", int'(free_cnt), 1);
        expect_err();
        free_req  = 1'b1;
        free_slot = 4'd14;
        tick();
        chk("ill14_cnt", int'(free_cnt), 1);
        expect_err();
        free_slot = 4'd7;
        tick();
        free_req = 1'b0;
        chk("ill7_cnt", int'(free_cnt), 1);
        tick();
        drain("illegal", 4);
        exp_slot_q.push_back(7);
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
        tick();
        tick();
        drain("ill_alloc", 4);
        chk("ill_none", int'(none_free), 1);
        chk("ill_rdy", int'(rdy), 0);

        // ---- double free of the candidate together with alloc ----
        free_req  = 1'b1;
        free_slot = 4'd2;
        tick();
        free_req = 1'b0;
        tick();
        chk("dbl_rdy", int'(rdy), 1);
        exp_slot_q.push_back(2);
        expect_err();
        alloc_req = 1'b1;
        free_req  = 1'b1;
        free_slot = 4'd2;
        tick();
        alloc_req = 1'b0;
        free_req  = 1'b0;
        chk("dbl_cnt", int'(free_cnt), 0);
        chk("dbl_none", int'(none_free), 1);
        tick();
        tick();
        chk("dbl_rdy_after", int'(rdy), 0);
        drain("dbl", 4);

        // ---- async reset with slots 8..11 allocated ----
        for (int i = 0; i < 8; i++) begin
            free_req  = 1'b1;
            free_slot = 4'(i);
            tick();
        end
        free_req = 1'b0;
        tick();
        chk("pre_rst_cnt", int'(free_cnt), 8);
        chk("pre_rst_slot", int'(alloc_slot), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt", int'(free_cnt), 12);
        chk("arst_slot", int'(alloc_slot), 0);
        chk("arst_rdy", int'(rdy), 0);
        chk("arst_none", int'(none_free), 0);
        chk("arst_ack", int'(alloc_ack), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_rdy", int'(rdy), 1);
        exp_slot_q.push_back(11);
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
        tick();
        drain("post_rst", 4);
        chk("post_rst_cnt", int'(free_cnt), 11);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, limit 50000 ns");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
